// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the cache-line memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  localparam int DEF_LINE_WORDS  = 8;
  localparam int DEF_MEM_LATENCY = 2;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-requester round-robin arbiter; bit 0 = instruction cache, bit 1 = data cache.
module mem_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic pref_dc;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = pref_dc ? 2'b10 : 2'b01;
    end
  end

  // After a grant, preference moves to the side that was not served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pref_dc <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      pref_dc <= gnt[0];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences whole cache-line fills/writebacks between the I/D caches and main
// memory, one word per MEM_LATENCY cycles, one line transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                          MEM_CLK,
  input  logic                          RST_N,
  input  logic                          IC_REQ,
  input  logic [31:0]                   IC_ADDR,
  output logic                          IC_GNT,
  output logic                          IC_WORD_VALID,
  output logic                          IC_DONE,
  input  logic                          DC_REQ,
  input  logic                          DC_WE,
  input  logic [31:0]                   DC_ADDR,
  input  logic [31:0]                   DC_WDATA,
  output logic                          DC_GNT,
  output logic                          DC_WORD_VALID,
  output logic                          DC_DONE,
  output logic [$clog2(LINE_WORDS)-1:0] WORD_IDX,
  output logic [31:0]                   RDATA,
  output logic                          MEM_RDEN1,
  output logic [13:0]                   MEM_ADDR1,
  output logic                          MEM_RDEN2,
  output logic                          MEM_WE2,
  output logic [31:0]                   MEM_ADDR2,
  output logic [31:0]                   MEM_DIN2,
  input  logic [31:0]                   MEM_DOUT1,
  input  logic [31:0]                   MEM_DOUT2
);

  localparam int WI = $clog2(LINE_WORDS);
  localparam int CW = $clog2(MEM_LATENCY);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);
  localparam logic [WI-1:0] IDX_LAST = WI'(LINE_WORDS - 1);

  arb_state_e     state_q, state_d;
  owner_e         owner_q;
  logic           we_q;
  logic [WI-1:0]  idx_q;
  logic [CW-1:0]  cnt_q;
  logic [29-WI:0] line_hi_q;

  logic [1:0]     arb_req, arb_gnt;
  logic           arb_adv;
  logic           grant_now;
  logic           word_last;
  logic [29:0]    word_addr;
  logic           unused_addr_lsbs;

  assign arb_req   = {DC_REQ, IC_REQ};
  assign arb_adv   = (state_q == IDLE);
  assign grant_now = (state_q == IDLE) && (arb_gnt != 2'b00);
  assign word_last = (cnt_q == CNT_LAST);
  assign word_addr = {line_hi_q, idx_q};

  // Byte offset and word-in-line bits of the request address are not needed.
  assign unused_addr_lsbs = ^{IC_ADDR[1+WI:0], DC_ADDR[1+WI:0]};

  mem_rr_arb u_rr_arb (
    .clk     (MEM_CLK),
    .rst_n   (RST_N),
    .req     (arb_req),
    .advance (arb_adv),
    .gnt     (arb_gnt)
  );

  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge MEM_CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner_q <= OWN_DC;
      we_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else if (grant_now) begin
      owner_q <= arb_gnt[1] ? OWN_DC : OWN_IC;
      we_q    <= arb_gnt[1] & DC_WE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == XFER) begin
      if (word_last) begin
        cnt_q <= '0;
        if (idx_q != IDX_LAST) begin
          idx_q <= idx_q + WI'(1);
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Line address is payload only; every use is gated by state, so no reset.
  always_ff @(posedge MEM_CLK) begin
    if (grant_now) begin
      line_hi_q <= arb_gnt[1] ? DC_ADDR[31:2+WI] : IC_ADDR[31:2+WI];
    end
  end

  always_comb begin
    state_d       = state_q;
    IC_GNT        = 1'b0;
    IC_WORD_VALID = 1'b0;
    IC_DONE       = 1'b0;
    DC_GNT        = 1'b0;
    DC_WORD_VALID = 1'b0;
    DC_DONE       = 1'b0;
    WORD_IDX      = '0;
    RDATA         = '0;
    MEM_RDEN1     = 1'b0;
    MEM_ADDR1     = '0;
    MEM_RDEN2     = 1'b0;
    MEM_WE2       = 1'b0;
    MEM_ADDR2     = '0;
    MEM_DIN2      = '0;

    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          state_d = XFER;
        end
      end

      XFER: begin
        WORD_IDX = idx_q;
        if (owner_q == OWN_IC) begin
          IC_GNT        = 1'b1;
          MEM_RDEN1     = 1'b1;
          MEM_ADDR1     = word_addr[13:0];
          IC_WORD_VALID = word_last;
          if (word_last) begin
            RDATA = MEM_DOUT1;
          end
        end else begin
          DC_GNT        = 1'b1;
          MEM_ADDR2     = {2'b00, word_addr};
          DC_WORD_VALID = word_last;
          if (we_q) begin
            // One write strobe per word; the rest of the slot is access latency.
            MEM_WE2  = (cnt_q == '0);
            MEM_DIN2 = DC_WDATA;
          end else begin
            MEM_RDEN2 = 1'b1;
            if (word_last) begin
              RDATA = MEM_DOUT2;
            end
          end
        end
        if (word_last && (idx_q == IDX_LAST)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        IC_GNT  = (owner_q == OWN_IC);
        IC_DONE = (owner_q == OWN_IC);
        DC_GNT  = (owner_q == OWN_DC);
        DC_DONE = (owner_q == OWN_DC);
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of line transactions plus hand sequences,
// with a word-level scoreboard fed at stimulus time and drained on WORD_VALID.
module tb_mem_arbiter;

  typedef struct {
    logic        dc;
    logic        we;
    logic [2:0]  idx;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        dc;
    logic        we;
    logic [31:0] addr;
    int          lat;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic MEM_CLK = 1'b0;
  always #5 MEM_CLK = ~MEM_CLK;
  always @(posedge MEM_CLK) cyc <= cyc + 1;

  logic        RST_N;
  logic        ic_req, dc_req, dc_we;
  logic [31:0] ic_addr, dc_addr, dc_wdata, wb_base;
  logic        ic_gnt, ic_wv, ic_done, dc_gnt, dc_wv, dc_done;
  logic [2:0]  word_idx;
  logic [31:0] rdata, mem_addr2, mem_din2, mem_dout1, mem_dout2;
  logic        mem_rden1, mem_rden2, mem_we2;
  logic [13:0] mem_addr1;

  logic        ic_req4;
  logic [31:0] ic_addr4;
  logic        ic_gnt4, ic_wv4, ic_done4, dc_gnt4, dc_wv4, dc_done4;
  logic [2:0]  word_idx4;
  logic [31:0] rdata4, mem_addr2_4, mem_din2_4, mem_dout1_4;
  logic        mem_rden1_4, mem_rden2_4, mem_we2_4;
  logic [13:0] mem_addr1_4;

  logic [31:0] dmem [0:16383];
  bit          dwr  [0:16383];

  exp_t sbq[$];
  exp_t sbq4[$];
  exp_t mon_e, mon4_e;
  vec_t vecs[5];
  logic prev_we2 = 1'b0;
  int   last_wv4 = -1;
  int   nwv4     = 0;

  logic [11:0] out_ctl;
  logic [31:0] out_bus;
  assign out_ctl = {ic_gnt, ic_wv, ic_done, dc_gnt, dc_wv, dc_done,
                    mem_rden1, mem_rden2, mem_we2, word_idx};
  assign out_bus = rdata | mem_din2 | mem_addr2 | {18'b0, mem_addr1};

  function automatic logic [31:0] imem_val(input logic [13:0] a);
    return 32'h1000_0000 + {18'b0, a};
  endfunction

  function automatic logic [31:0] dmem_rd(input logic [13:0] a);
    return dwr[a] ? dmem[a] : (32'h2000_0000 + {18'b0, a});
  endfunction

  assign mem_dout1   = mem_rden1   ? imem_val(mem_addr1)         : 32'h0;
  assign mem_dout2   = mem_rden2   ? dmem_rd(mem_addr2[13:0])    : 32'h0;
  assign mem_dout1_4 = mem_rden1_4 ? imem_val(mem_addr1_4)       : 32'h0;
  assign dc_wdata    = wb_base + {29'b0, word_idx};

  always @(posedge MEM_CLK) begin
    if (mem_we2) begin
      dmem[mem_addr2[13:0]] <= mem_din2;
      dwr[mem_addr2[13:0]]  <= 1'b1;
    end
  end

  mem_arbiter #(.LINE_WORDS(8), .MEM_LATENCY(2)) u_dut (
    .MEM_CLK(MEM_CLK), .RST_N(RST_N),
    .IC_REQ(ic_req), .IC_ADDR(ic_addr), .IC_GNT(ic_gnt),
    .IC_WORD_VALID(ic_wv), .IC_DONE(ic_done),
    .DC_REQ(dc_req), .DC_WE(dc_we), .DC_ADDR(dc_addr), .DC_WDATA(dc_wdata),
    .DC_GNT(dc_gnt), .DC_WORD_VALID(dc_wv), .DC_DONE(dc_done),
    .WORD_IDX(word_idx), .RDATA(rdata),
    .MEM_RDEN1(mem_rden1), .MEM_ADDR1(mem_addr1),
    .MEM_RDEN2(mem_rden2), .MEM_WE2(mem_we2), .MEM_ADDR2(mem_addr2),
    .MEM_DIN2(mem_din2), .MEM_DOUT1(mem_dout1), .MEM_DOUT2(mem_dout2)
  );

  mem_arbiter #(.LINE_WORDS(8), .MEM_LATENCY(4)) u_dut4 (
    .MEM_CLK(MEM_CLK), .RST_N(RST_N),
    .IC_REQ(ic_req4), .IC_ADDR(ic_addr4), .IC_GNT(ic_gnt4),
    .IC_WORD_VALID(ic_wv4), .IC_DONE(ic_done4),
    .DC_REQ(1'b0), .DC_WE(1'b0), .DC_ADDR(32'h0), .DC_WDATA(32'h0),
    .DC_GNT(dc_gnt4), .DC_WORD_VALID(dc_wv4), .DC_DONE(dc_done4),
    .WORD_IDX(word_idx4), .RDATA(rdata4),
    .MEM_RDEN1(mem_rden1_4), .MEM_ADDR1(mem_addr1_4),
    .MEM_RDEN2(mem_rden2_4), .MEM_WE2(mem_we2_4), .MEM_ADDR2(mem_addr2_4),
    .MEM_DIN2(mem_din2_4), .MEM_DOUT1(mem_dout1_4), .MEM_DOUT2(32'h0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic dc, input logic we, input int i,
                                  input logic [29:0] wa);
    exp_t e;
    e.dc   = dc;
    e.we   = we;
    e.idx  = 3'(i);
    e.addr = {2'b00, wa};
    if (!dc)     e.data = imem_val(wa[13:0]);
    else if (we) e.data = wb_base + 32'(i);
    else         e.data = dmem_rd(wa[13:0]);
    return e;
  endfunction

  task automatic push_line(input logic dc, input logic we, input logic [31:0] addr);
    logic [29:0] base;
    base = addr[31:2] & ~30'h7;
    for (int i = 0; i < 8; i++) sbq.push_back(mk_exp(dc, we, i, base | 30'(i)));
  endtask

  task automatic run_txn(input logic dc, input logic we, input logic [31:0] addr,
                         input int exp_lat, input int drop_after);
    int   n;
    logic seen;
    push_line(dc, we, addr);
    @(negedge MEM_CLK);
    if (dc) begin dc_req = 1'b1; dc_we = we; dc_addr = addr; end
    else    begin ic_req = 1'b1; ic_addr = addr; end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge MEM_CLK);
      n++;
      @(negedge MEM_CLK);
      if (n == 1) check("gnt_next_cycle", 64'(dc ? dc_gnt : ic_gnt), 64'd1);
      if (drop_after != 0 && n == drop_after) begin ic_req = 1'b0; dc_req = 1'b0; end
      if (dc ? dc_done : ic_done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("line_latency", 64'(n), 64'(exp_lat));
    ic_req = 1'b0;
    dc_req = 1'b0;
    @(posedge MEM_CLK);
    @(negedge MEM_CLK);
    check("done_one_cycle", 64'(ic_done | dc_done), 64'd0);
    check("sb_drained", 64'(sbq.size()), 64'd0);
  endtask

  // Word-level scoreboard and invariants for the MEM_LATENCY=2 instance.
  always @(negedge MEM_CLK) begin
    if (RST_N) begin
      check("gnt_overlap", 64'(ic_gnt & dc_gnt), 64'd0);
      if (!(ic_wv || dc_wv)) check("rdata_idle_zero", 64'(rdata), 64'd0);
      if (mem_we2) check("we2_single_cycle", 64'(prev_we2), 64'd0);
      if (ic_wv || dc_wv) begin
        check("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          check("wv_owner", 64'(dc_wv), 64'(mon_e.dc));
          check("word_idx", 64'(word_idx), 64'(mon_e.idx));
          if (mon_e.dc) begin
            check("mem_addr2", 64'(mem_addr2), 64'(mon_e.addr));
            check("port1_idle", 64'({mem_rden1, mem_addr1}), 64'd0);
            if (mon_e.we) check("wb_mem_word", 64'(dmem_rd(mon_e.addr[13:0])), 64'(mon_e.data));
            else          check("rdata_dc", 64'(rdata), 64'(mon_e.data));
          end else begin
            check("mem_addr1", 64'(mem_addr1), 64'(mon_e.addr[13:0]));
            check("port2_idle", 64'({mem_rden2, mem_we2, mem_addr2}), 64'd0);
            check("rdata_ic", 64'(rdata), 64'(mon_e.data));
          end
        end
      end
    end
    prev_we2 = mem_we2;
  end

  always @(negedge MEM_CLK) begin
    if (RST_N && ic_wv4) begin
      nwv4++;
      if (last_wv4 >= 0) check("wv_spacing_lat4", 64'(cyc - last_wv4), 64'd4);
      last_wv4 = cyc;
      check("sb4_nonempty", 64'(sbq4.size() != 0), 64'd1);
      if (sbq4.size() != 0) begin
        mon4_e = sbq4.pop_front();
        check("word_idx_lat4", 64'(word_idx4), 64'(mon4_e.idx));
        check("mem_addr1_lat4", 64'(mem_addr1_4), 64'(mon4_e.addr[13:0]));
        check("rdata_lat4", 64'(rdata4), 64'(mon4_e.data));
        check("port2_idle_lat4",
              64'({mem_rden2_4, mem_we2_4, dc_gnt4, dc_wv4, dc_done4} | 5'(|{mem_addr2_4, mem_din2_4})),
              64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, k, last_done;
    RST_N = 1'b0;
    ic_req = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0;
    wb_base = 32'hA0;
    ic_req4 = 1'b0; ic_addr4 = '0;
    repeat (3) @(posedge MEM_CLK);
    @(negedge MEM_CLK);
    check("reset_ctl_zero", 64'(out_ctl), 64'd0);
    check("reset_bus_zero", 64'(out_bus), 64'd0);

    // Contention from reset release: DC, then IC, then DC again.
    push_line(1'b1, 1'b0, 32'h300);
    push_line(1'b0, 1'b0, 32'h200);
    push_line(1'b1, 1'b0, 32'h300);
    RST_N = 1'b1;
    ic_req = 1'b1; ic_addr = 32'h200;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h300;
    k = 0; n = 0; last_done = 0;
    while (k < 3 && n < 300) begin
      @(posedge MEM_CLK);
      n++;
      @(negedge MEM_CLK);
      if (ic_done || dc_done) begin
        check("contention_order", 64'(dc_done), (k == 1) ? 64'd0 : 64'd1);
        if (k == 1) begin
          check("done_to_done_gap", 64'(n - last_done), 64'd18);
          ic_req = 1'b0;
        end
        if (k == 2) dc_req = 1'b0;
        last_done = n;
        k++;
      end
    end
    check("contention_lines", 64'(k), 64'd3);
    @(negedge MEM_CLK);
    check("contention_sb_drained", 64'(sbq.size()), 64'd0);

    vecs[0] = '{dc: 1'b0, we: 1'b0, addr: 32'h0000_0044, lat: 17};
    vecs[1] = '{dc: 1'b1, we: 1'b1, addr: 32'h0000_0100, lat: 17};
    vecs[2] = '{dc: 1'b1, we: 1'b0, addr: 32'h0000_0100, lat: 17};
    vecs[3] = '{dc: 1'b0, we: 1'b0, addr: 32'h0001_001F, lat: 17};
    vecs[4] = '{dc: 1'b1, we: 1'b0, addr: 32'h1234_5678, lat: 17};
    for (int v = 0; v < 5; v++) begin
      run_txn(vecs[v].dc, vecs[v].we, vecs[v].addr, vecs[v].lat, 0);
    end
    for (int i = 0; i < 8; i++) begin
      check("wb_line_content", 64'(dmem_rd(14'(32'h40 + i))), 64'(32'hA0 + i));
    end

    // Requester drops REQ five cycles into the line.
    run_txn(1'b0, 1'b0, 32'h0000_0080, 17, 5);

    // Asynchronous reset in the middle of a DC fill.
    push_line(1'b1, 1'b0, 32'h500);
    @(negedge MEM_CLK);
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h500;
    n = 0;
    while (word_idx != 3'd3 && n < 100) begin
      @(negedge MEM_CLK);
      n++;
    end
    check("reached_word3", 64'(word_idx), 64'd3);
    #2 RST_N = 1'b0;
    #1;
    check("async_reset_ctl", 64'(out_ctl), 64'd0);
    check("async_reset_bus", 64'(out_bus), 64'd0);
    dc_req = 1'b0;
    sbq.delete();
    repeat (2) @(posedge MEM_CLK);
    @(negedge MEM_CLK);
    RST_N = 1'b1;
    run_txn(1'b0, 1'b0, 32'h0000_0600, 17, 0);

    // MEM_LATENCY = 4 instance.
    for (int i = 0; i < 8; i++) sbq4.push_back(mk_exp(1'b0, 1'b0, i, 30'h10 | 30'(i)));
    @(negedge MEM_CLK);
    ic_req4 = 1'b1; ic_addr4 = 32'h0000_0044;
    n = 0;
    while (!ic_done4 && n < 200) begin
      @(posedge MEM_CLK);
      n++;
      @(negedge MEM_CLK);
    end
    ic_req4 = 1'b0;
    check("line_latency_lat4", 64'(n), 64'd33);
    check("words_seen_lat4", 64'(nwv4), 64'd8);
    check("sb4_drained", 64'(sbq4.size()), 64'd0);

    repeat (2) @(posedge MEM_CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences cache-line transfers between the two cache controllers and the shared main memory. Accepts line-fill requests from the instruction cache and line-fill or line-writeback requests from the data cache, arbitrates round-robin, and drives the memory's read/write ports one word at a time with a fixed per-word access latency. Only one line transaction is in flight at a time. Streams words back to the owning cache with an index and a valid strobe.

## Interface
- LINE_WORDS, 8: words per cache line; power of two, ≥2; WI = log2(LINE_WORDS).
- MEM_LATENCY, 2: cycles per word access; ≥2.
- MEM_CLK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IC_REQ  in  1  instruction-cache fill request; held until IC_DONE.
- IC_ADDR  in  32  byte address of line; low 2+WI bits ignored.
- IC_GNT  out  1  high while IC owns memory.
- IC_WORD_VALID  out  1  RDATA holds word IC_WORD_IDX of the IC line.
- IC_DONE  out  1  one-cycle pulse, IC line complete.
- DC_REQ  in  1  data-cache request; held until DC_DONE.
- DC_WE  in  1  1 = writeback, 0 = fill; sampled at grant.
- DC_ADDR  in  32  byte address of line; low 2+WI bits ignored.
- DC_WDATA  in  32  writeback word for current DC_WORD_IDX.
- DC_GNT  out  1  high while DC owns memory.
- DC_WORD_VALID  out  1  fill: RDATA valid; writeback: word DC_WORD_IDX written.
- DC_DONE  out  1  one-cycle pulse, DC line complete.
- WORD_IDX  out  WI  current word index (shared by both owners).
- RDATA  out  32  read data to owner.
- MEM_RDEN1  out  1  instruction port read enable.
- MEM_ADDR1  out  14  instruction port word address.
- MEM_RDEN2, MEM_WE2  out  1  data port read / write enable.
- MEM_ADDR2  out  32  data port word address, zero-extended.
- MEM_DIN2  out  32  data port write data.
- MEM_DOUT1, MEM_DOUT2  in  32  memory read data.

## Operation
- States: IDLE, XFER, DONE. Reset → IDLE; all outputs 0; RR pointer = "DC preferred".
- IDLE: both REQ high → grant preferred requester; one high → grant it; none → stay. On grant: latch owner, line word address (ADDR[31:2] with low WI bits cleared), DC_WE; idx=0, cnt=0; go XFER. Pointer flips to the non-granted side after each grant.
- XFER: owner's GNT high. Word address = line base | idx. IC → port 1 (MEM_ADDR1 = word addr[13:0]); DC → port 2. Non-owner port enables 0, addresses 0.
- Read word: RDENx high for all MEM_LATENCY cycles; at cnt = MEM_LATENCY-1, owner WORD_VALID = 1, RDATA = MEM_DOUTx (combinational pass-through).
- Write word: MEM_WE2 high only at cnt = 0, MEM_DIN2 = DC_WDATA; DC_WORD_VALID at cnt = MEM_LATENCY-1. DC_WDATA must track WORD_IDX for the whole word.
- At cnt = MEM_LATENCY-1: cnt←0; idx = LINE_WORDS-1 → DONE, else idx+1.
- DONE: owner DONE pulse, GNT still high, memory enables 0; REQ ignored; → IDLE.
- RDATA = 0 when no WORD_VALID.

## Timing
- Grant: REQ high in IDLE at edge k → GNT and first access from cycle k+1.
- Line latency: request edge to DONE = 1 + LINE_WORDS·MEM_LATENCY cycles; IDLE re-entered one cycle after DONE; back-to-back lines have 2 idle-side cycles between last word and next grant.
- REQ dropping mid-XFER: ignored, transaction completes.
- Requester must drop REQ in the cycle after DONE; still high in IDLE is a new request.
- Simultaneous REQ at reset release: DC wins; next contention IC wins.
- Reset assertion mid-XFER: immediate abort, all outputs 0 asynchronously, partial writeback left in memory.
- Width: idx wraps never (bounded by DONE); cnt width = clog2(MEM_LATENCY).

## Structure
- Package mem_arb_pkg: state enum (IDLE, XFER, DONE), owner enum (OWN_IC, OWN_DC), default LINE_WORDS/MEM_LATENCY constants.
- Sub-module mem_rr_arb: 2-requester round-robin arbiter (req[1:0], advance, gnt[1:0], pointer flop with async reset).

## Test plan
- IC fill, IC_ADDR=0x0000_0044, LINE_WORDS=8, MEM_LATENCY=2 → MEM_ADDR1 = 0x10..0x17, eight IC_WORD_VALID pulses every 2 cycles, IC_DONE at cycle 17.
- DC writeback, DC_ADDR=0x100, DC_WDATA = 0xA0+idx → MEM_WE2 single-cycle per word, memory words 0x40..0x47 = 0xA0..0xA7, DC_DONE once.
- Both REQ high after reset, then both high again → DC granted first, IC second; no overlap of GNTs.
- IC_REQ dropped mid-XFER → all 8 words still issued, IC_DONE pulses.
- RST_N low at word 3 of DC fill → outputs 0 same cycle, state IDLE; new IC request after release served normally.
- MEM_LATENCY=4 → WORD_VALID spacing 4 cycles, DONE at cycle 33.
